frame_buffer_multi: RTL

//   Parametrised N-buffer (double/triple) frame store; replaces the fixed 1-bit, 640x480, two-buffer store.

---
 rtl/frame_buffer_multi.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_multi.sv
// -----------------------------------------------------------------------------
// frame_buffer_multi
//   N-buffer (double or triple) frame store between the renderer (write side)
//   and the video scan-out (read side), single clock domain.
//   - Writer fills buffer wr_idx and pulses wr_frame_done when a frame is done.
//   - Scan-out reads buffer rd_idx and pulses rd_frame_start at vsync. At that
//     point a completed (pending) frame, if any, becomes the displayed one.
//   - Double buffering: the writer stalls (wr_ready=0) from frame-done until
//     the next frame start. No frame is ever lost.
//   - Triple buffering: the writer never stalls. A completed frame that is
//     replaced before it is shown is counted in dropped_frames (saturating).
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   ce               clock enable; low freezes all state, memory and rd_data
//   wr_en/addr/data  pixel write (accepted only while wr_ready)
//   wr_frame_done    1-cycle pulse, writer finished its frame
//   wr_ready         writer may write pixels / finish a frame
//   rd_addr/rd_data  scan-out read, 1 cycle latency, 0 for out-of-range addr
//   rd_frame_start   1-cycle pulse at the scan-out frame boundary
//   rd_buf_idx       buffer currently displayed
//   dropped_frames   completed frames that were never displayed
// -----------------------------------------------------------------------------
module frame_buffer_multi #(
    parameter  int PIXEL_W  = 1,
    parameter  int WIDTH    = 640,
    parameter  int HEIGHT   = 480,
    parameter  int NUM_BUFS = 2,
    parameter  int DROP_W   = 8,
    localparam int DEPTH    = WIDTH * HEIGHT,
    localparam int ADDR_W   = $clog2(WIDTH * HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               wr_frame_done,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIXEL_W-1:0] rd_data,
    input  logic               rd_frame_start,
    output logic [1:0]         rd_buf_idx,
    output logic [DROP_W-1:0]  dropped_frames
);

    if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
        $error("frame_buffer_multi: NUM_BUFS must be 2 or 3");
    end

    typedef logic [1:0] buf_idx_t;

    localparam int               MEM_DEPTH = NUM_BUFS * DEPTH;
    localparam int               MEM_AW    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W + 1)'(DEPTH);

    // All buffers live in one flat array; buffer b occupies [b*DEPTH, b*DEPTH+DEPTH).
    logic [PIXEL_W-1:0] mem [MEM_DEPTH];

    buf_idx_t           rd_idx_q,     rd_idx_d;
    buf_idx_t           wr_idx_q,     wr_idx_d;
    buf_idx_t           pend_idx_q,   pend_idx_d;
    logic               pend_valid_q, pend_valid_d;
    logic               wr_ready_q,   wr_ready_d;
    logic [DROP_W-1:0]  drop_q,       drop_d;
    logic [PIXEL_W-1:0] rd_data_q;

    logic               wr_in_range, rd_in_range;
    logic [MEM_AW-1:0]  wr_mem_addr, rd_mem_addr;
    logic               done_acc;
    logic               eff_valid;
    buf_idx_t           eff_idx;
    logic               drop_inc;

    // Address decode. Addresses at or beyond DEPTH never touch memory; they
    // must be filtered before forming the flat index, or they would alias
    // into the next buffer.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_mem_addr = MEM_AW'(wr_idx_q) * MEM_AW'(DEPTH) + MEM_AW'(wr_addr);
    assign rd_mem_addr = MEM_AW'(rd_idx_q) * MEM_AW'(DEPTH) + MEM_AW'(rd_addr);

    // A done pulse is only honoured while the writer is allowed to finish.
    assign done_acc  = wr_frame_done & wr_ready_q;
    assign eff_valid = pend_valid_q | done_acc;
    assign eff_idx   = done_acc ? wr_idx_q : pend_idx_q;

    // NOTE: every signal written here gets its default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        rd_idx_d     = rd_idx_q;
        wr_idx_d     = wr_idx_q;
        pend_idx_d   = pend_idx_q;
        pend_valid_d = pend_valid_q;
        wr_ready_d   = wr_ready_q;
        drop_inc     = 1'b0;

        if (NUM_BUFS == 2) begin
            if (rd_frame_start && eff_valid) begin
                // The completed frame is always in wr_idx: the writer stalled
                // on it. A same-cycle done swaps at once and never stalls.
                rd_idx_d     = wr_idx_q;
                wr_idx_d     = rd_idx_q;
                pend_valid_d = 1'b0;
                wr_ready_d   = 1'b1;
            end else if (done_acc) begin
                pend_idx_d   = wr_idx_q;
                pend_valid_d = 1'b1;
                wr_ready_d   = 1'b0;
            end
        end else begin
            wr_ready_d = 1'b1;
            if (rd_frame_start && eff_valid) begin
                rd_idx_d     = eff_idx;
                pend_valid_d = 1'b0;
                if (done_acc) begin
                    // Just-completed frame goes straight to display; any older
                    // pending frame is discarded and its buffer becomes spare.
                    wr_idx_d = rd_idx_q;
                    drop_inc = pend_valid_q;
                end
            end else if (done_acc) begin
                if (pend_valid_q) begin
                    // Overwrite the stale pending frame's buffer next.
                    wr_idx_d = pend_idx_q;
                    drop_inc = 1'b1;
                end else begin
                    // Indices are 0,1,2: the free one is 3 - wr - rd.
                    wr_idx_d = buf_idx_t'(2'd3 - wr_idx_q - rd_idx_q);
                end
                pend_idx_d   = wr_idx_q;
                pend_valid_d = 1'b1;
            end
        end

        drop_d = drop_q;
        if (drop_inc && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx_q     <= 2'd0;
            wr_idx_q     <= 2'd1;
            pend_idx_q   <= 2'd0;
            pend_valid_q <= 1'b0;
            wr_ready_q   <= 1'b1;
            drop_q       <= '0;
            rd_data_q    <= '0;
        end else if (ce) begin
            rd_idx_q     <= rd_idx_d;
            wr_idx_q     <= wr_idx_d;
            pend_idx_q   <= pend_idx_d;
            pend_valid_q <= pend_valid_d;
            wr_ready_q   <= wr_ready_d;
            drop_q       <= drop_d;
            rd_data_q    <= rd_in_range ? mem[rd_mem_addr] : '0;
        end
    end

    // NOTE: the pixel array has no reset; clearing it would need a full sweep
    // and it is always written before it is displayed.
    always_ff @(posedge clk) begin
        if (ce && wr_en && wr_ready_q && wr_in_range) begin
            mem[wr_mem_addr] <= wr_data;
        end
    end

    assign wr_ready       = wr_ready_q;
    assign rd_data        = rd_data_q;
    assign rd_buf_idx     = rd_idx_q;
    assign dropped_frames = drop_q;

endmodule
